fifo_ring: RTL and testbench

// Pointer-based circular FIFO, successor to the shift-register FIFOs: no data shifting, any depth (not just 2^n).

---
 rtl/fifo_ring.sv | 133 +++++++++++++
 tb/tb_fifo_ring.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ring.sv
// Pointer-based circular FIFO with show-ahead output, threshold flags, free-slot count,
// synchronous flush and sticky overflow/underflow flags; push/drop level- or edge-sensitive.
module fifo_ring #(
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_LENGTH  = 16,
  parameter int EDGE_MODE    = 0,
  parameter int AF_TH        = 12,
  parameter int AE_TH        = 2,
  parameter int COUNTER_SIZE = $clog2(FIFO_LENGTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic                    push,
  output logic [DATA_WIDTH-1:0]   data_o,
  input  logic                    drop,
  output logic                    fifo_empty,
  output logic                    fifo_full,
  output logic                    almost_empty,
  output logic                    almost_full,
  output logic [COUNTER_SIZE-1:0] awaiting_count,
  output logic [COUNTER_SIZE-1:0] free_count,
  output logic                    overflow,
  output logic                    underflow,
  input  logic                    clear_err
);

  localparam int PTR_W = (FIFO_LENGTH > 2) ? $clog2(FIFO_LENGTH) : 1;
  localparam logic [PTR_W-1:0]        L_LAST = PTR_W'(FIFO_LENGTH - 1);
  localparam logic [COUNTER_SIZE-1:0] L_LEN  = COUNTER_SIZE'(FIFO_LENGTH);
  localparam logic [COUNTER_SIZE-1:0] L_AF   = COUNTER_SIZE'(AF_TH);
  localparam logic [COUNTER_SIZE-1:0] L_AE   = COUNTER_SIZE'(AE_TH);
  localparam logic [COUNTER_SIZE-1:0] L_ONE  = COUNTER_SIZE'(1);

  if (FIFO_LENGTH < 2 || AF_TH < 0 || AF_TH > FIFO_LENGTH ||
      AE_TH < 0 || AE_TH > FIFO_LENGTH) begin : g_bad_params
    $error("fifo_ring: FIFO_LENGTH must be >= 2 and thresholds within 0..FIFO_LENGTH");
  end

  logic [DATA_WIDTH-1:0]   r_mem [FIFO_LENGTH];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [COUNTER_SIZE-1:0] r_count;
  logic                    r_overflow;
  logic                    r_underflow;

  logic w_p;
  logic w_d;
  logic w_empty;
  logic w_full;
  logic w_wr_en;
  logic w_rd_en;
  logic w_ovf_set;
  logic w_udf_set;

  // Request semantics: push offers data_i for storage at the next edge; drop
  // declares that the current data_o has been consumed. Neither is back-pressured;
  // a request the FIFO cannot honour is discarded and recorded in the sticky flags.
  if (EDGE_MODE != 0) begin : g_edge
    logic r_push_d;
    logic r_drop_d;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_push_d <= 1'b0;
        r_drop_d <= 1'b0;
      end else begin
        r_push_d <= push;
        r_drop_d <= drop;
      end
    end
    assign w_p = push & ~r_push_d;
    assign w_d = drop & ~r_drop_d;
  end else begin : g_level
    assign w_p = push;
    assign w_d = drop;
  end

  function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] ptr);
    return (ptr == L_LAST) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == L_LEN);
  // A simultaneous drop frees the head slot, so a push on a full FIFO still lands.
  assign w_wr_en   = ~flush & w_p & (w_d | ~w_full);
  assign w_rd_en   = ~flush & w_d & ~w_empty;
  assign w_ovf_set = ~flush & w_p & w_full & ~w_d;
  assign w_udf_set = ~flush & w_d & w_empty;

  always_ff @(posedge clk) begin
    if (!rst && w_wr_en) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= w_ovf_set | (r_overflow & ~clear_err);
      r_underflow <= w_udf_set | (r_underflow & ~clear_err);
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_wr_en) r_wr_ptr <= f_next(r_wr_ptr);
        if (w_rd_en) r_rd_ptr <= f_next(r_rd_ptr);
        case ({w_wr_en, w_rd_en})
          2'b10:   r_count <= r_count + L_ONE;
          2'b01:   r_count <= r_count - L_ONE;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign data_o         = w_empty ? '0 : r_mem[r_rd_ptr];
  assign fifo_empty     = w_empty;
  assign fifo_full      = w_full;
  assign almost_empty   = (r_count <= L_AE);
  assign almost_full    = (r_count >= L_AF);
  assign awaiting_count = r_count;
  assign free_count     = L_LEN - r_count;
  assign overflow       = r_overflow;
  assign underflow      = r_underflow;

endmodule

// File: tb/tb_fifo_ring.sv
// Bench for fifo_ring: level-mode instance with a data scoreboard, plus an edge-mode instance.
module tb_fifo_ring;
  localparam int DW  = 8;
  localparam int LEN = 5;
  localparam int CW  = $clog2(LEN + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          a_flush, a_push, a_drop, a_clear;
  logic [DW-1:0] a_din, a_dout;
  logic          a_empty, a_full, a_ae, a_af, a_ovf, a_udf;
  logic [CW-1:0] a_cnt, a_free;

  logic          e_flush, e_push, e_drop, e_clear;
  logic [DW-1:0] e_din, e_dout;
  logic          e_empty, e_full, e_ae, e_af, e_ovf, e_udf;
  logic [CW-1:0] e_cnt, e_free;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_exp;

  always #5 clk = ~clk;

  fifo_ring #(.DATA_WIDTH(DW), .FIFO_LENGTH(LEN), .EDGE_MODE(0), .AF_TH(4), .AE_TH(1)) u_lvl (
    .clk(clk), .rst(rst), .flush(a_flush), .data_i(a_din), .push(a_push), .data_o(a_dout),
    .drop(a_drop), .fifo_empty(a_empty), .fifo_full(a_full), .almost_empty(a_ae),
    .almost_full(a_af), .awaiting_count(a_cnt), .free_count(a_free), .overflow(a_ovf),
    .underflow(a_udf), .clear_err(a_clear)
  );

  fifo_ring #(.DATA_WIDTH(DW), .FIFO_LENGTH(LEN), .EDGE_MODE(1), .AF_TH(4), .AE_TH(1)) u_edge (
    .clk(clk), .rst(rst), .flush(e_flush), .data_i(e_din), .push(e_push), .data_o(e_dout),
    .drop(e_drop), .fifo_empty(e_empty), .fifo_full(e_full), .almost_empty(e_ae),
    .almost_full(e_af), .awaiting_count(e_cnt), .free_count(e_free), .overflow(e_ovf),
    .underflow(e_udf), .clear_err(e_clear)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_cyc(input logic p, input logic d, input logic [DW-1:0] v);
    a_push = p;
    a_drop = d;
    a_din  = v;
    tick();
    a_push = 1'b0;
    a_drop = 1'b0;
  endtask

  task automatic a_wr(input logic [DW-1:0] v);
    exp_q.push_back(v);
    a_cyc(1'b1, 1'b0, v);
  endtask

  task automatic a_rd();
    a_cyc(1'b0, 1'b1, '0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " empty"},  32'(a_empty), 32'd1);
    chk({tag, " full"},   32'(a_full),  32'd0);
    chk({tag, " ae"},     32'(a_ae),    32'd1);
    chk({tag, " af"},     32'(a_af),    32'd0);
    chk({tag, " count"},  32'(a_cnt),   32'd0);
    chk({tag, " free"},   32'(a_free),  32'd5);
    chk({tag, " data_o"}, 32'(a_dout),  32'd0);
    chk({tag, " ovf"},    32'(a_ovf),   32'd0);
    chk({tag, " udf"},    32'(a_udf),   32'd0);
  endtask

  // Monitor: whenever a drop is about to consume a valid head, that head must be the oldest expected word.
  always @(negedge clk) begin
    if (!rst && a_drop && !a_empty) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL data_o order: got 0x%0h, want nothing (queue empty)", a_dout);
      end else begin
        m_exp = exp_q.pop_front();
        chk("data_o order", 32'(a_dout), 32'(m_exp));
      end
    end
  end

  initial begin
    a_flush = 0; a_push = 0; a_drop = 0; a_clear = 0; a_din = '0;
    e_flush = 0; e_push = 1; e_drop = 0; e_clear = 0; e_din = 8'h7E;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset("reset");
    chk("edge reset count", 32'(e_cnt), 32'd0);

    // Edge mode: push held through reset and 4 cycles after -> one entry.
    repeat (4) tick();
    chk("edge held push count", 32'(e_cnt), 32'd1);
    chk("edge held push data", 32'(e_dout), 32'h7E);
    e_push = 0; tick();
    e_din = 8'h7F; e_push = 1; tick();
    e_push = 0; tick();
    chk("edge second push count", 32'(e_cnt), 32'd2);
    e_drop = 1; tick();
    chk("edge drop1 data", 32'(e_dout), 32'h7F);
    e_drop = 0; tick();
    e_drop = 1; tick();
    e_drop = 0;
    chk("edge drop toggle count", 32'(e_cnt), 32'd0);
    chk("edge drop toggle udf", 32'(e_udf), 32'd0);

    // Fill 0x11..0x15 and drain.
    for (int i = 0; i < 5; i++) begin
      a_wr(8'h11 + 8'(i));
      chk("fill count", 32'(a_cnt), 32'(i + 1));
      chk("fill af", 32'(a_af), (i + 1 >= 4) ? 32'd1 : 32'd0);
      chk("fill full", 32'(a_full), (i == 4) ? 32'd1 : 32'd0);
      if (i == 0) chk("first word latency", 32'(a_dout), 32'h11);
    end
    chk("full free", 32'(a_free), 32'd0);
    for (int i = 0; i < 5; i++) a_rd();
    chk("drain empty", 32'(a_empty), 32'd1);
    chk("drain data_o", 32'(a_dout), 32'd0);

    // Pointer wrap.
    for (int i = 0; i < 3; i++) a_wr(8'h01 + 8'(i));
    for (int i = 0; i < 3; i++) a_rd();
    for (int i = 0; i < 5; i++) a_wr(8'hA0 + 8'(i));
    chk("wrap count", 32'(a_cnt), 32'd5);
    chk("wrap full", 32'(a_full), 32'd1);
    for (int i = 0; i < 5; i++) a_rd();
    chk("wrap ovf", 32'(a_ovf), 32'd0);
    chk("wrap udf", 32'(a_udf), 32'd0);

    // Push and drop together while full.
    for (int i = 0; i < 5; i++) a_wr(8'h21 + 8'(i));
    exp_q.push_back(8'h55);
    a_cyc(1'b1, 1'b1, 8'h55);
    chk("full pd count", 32'(a_cnt), 32'd5);
    chk("full pd ovf", 32'(a_ovf), 32'd0);
    for (int i = 0; i < 5; i++) a_rd();
    chk("full pd drained", 32'(a_empty), 32'd1);

    // Overflow, underflow, clear_err.
    for (int i = 0; i < 5; i++) a_wr(8'h31 + 8'(i));
    a_cyc(1'b1, 1'b0, 8'h99);
    chk("overflow set", 32'(a_ovf), 32'd1);
    chk("overflow count", 32'(a_cnt), 32'd5);
    for (int i = 0; i < 5; i++) a_rd();
    a_rd();
    chk("underflow set", 32'(a_udf), 32'd1);
    chk("underflow count", 32'(a_cnt), 32'd0);
    a_clear = 1;
    a_rd();
    chk("clear vs new udf", 32'(a_udf), 32'd1);
    chk("clear ovf", 32'(a_ovf), 32'd0);
    a_cyc(1'b0, 1'b0, '0);
    a_clear = 0;
    chk("clear udf", 32'(a_udf), 32'd0);

    // Flush with push high keeps error flags.
    a_rd();
    for (int i = 0; i < 3; i++) a_wr(8'h41 + 8'(i));
    chk("pre flush count", 32'(a_cnt), 32'd3);
    a_flush = 1;
    a_cyc(1'b1, 1'b0, 8'h77);
    a_flush = 0;
    exp_q.delete();
    chk("flush count", 32'(a_cnt), 32'd0);
    chk("flush empty", 32'(a_empty), 32'd1);
    chk("flush free", 32'(a_free), 32'd5);
    chk("flush udf kept", 32'(a_udf), 32'd1);
    chk("flush ovf kept", 32'(a_ovf), 32'd0);
    a_wr(8'h61);
    chk("post flush data", 32'(a_dout), 32'h61);
    a_rd();

    // Reset mid-stream.
    a_wr(8'h71);
    a_wr(8'h72);
    a_push = 1; a_din = 8'h73; rst = 1;
    tick();
    rst = 0; a_push = 0;
    exp_q.delete();
    chk_reset("mid reset");

    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
